input_event_scheduler: RTL and testbench



---
 rtl/input_event_scheduler_pkg.sv | 60 ++++++
 rtl/input_event_scheduler_fifo.sv | 62 ++++++
 rtl/input_event_scheduler.sv | 155 +++++++++++++++
 tb/tb_input_event_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/input_event_scheduler_pkg.sv
// Shared definitions for the input event scheduler: source indices,
// event code layout, repeat FSM encoding and small ring/code helpers.
package input_event_pkg;

    localparam int NUM_SRC = 9;

    localparam logic [3:0] SRC_CMD0 = 4'd0;
    localparam logic [3:0] SRC_CMD1 = 4'd1;
    localparam logic [3:0] SRC_CMD2 = 4'd2;
    localparam logic [3:0] SRC_CMD3 = 4'd3;
    localparam logic [3:0] SRC_KEY0 = 4'd4;
    localparam logic [3:0] SRC_KEY1 = 4'd5;
    localparam logic [3:0] SRC_KEY2 = 4'd6;
    localparam logic [3:0] SRC_KEY3 = 4'd7;
    localparam logic [3:0] SRC_RPT  = 4'd8;

    localparam int EVT_IS_CMD = 3;
    localparam int EVT_IS_RPT = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    // (a + b) mod NUM_SRC for operands already inside the ring
    function automatic logic [3:0] ring_add(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 5'(NUM_SRC)) s = s - 5'(NUM_SRC);
        return s[3:0];
    endfunction

    // Event code written to the FIFO for a granted source
    function automatic logic [3:0] src_code(input logic [3:0] src, input logic [1:0] rpt_idx);
        logic [3:0] code;
        code = '0;
        if (src < SRC_KEY0) begin
            code[EVT_IS_CMD] = 1'b1;
            code[1:0]        = src[1:0];
        end else if (src < SRC_RPT) begin
            code[1:0]        = src[1:0];
        end else begin
            code[EVT_IS_RPT] = 1'b1;
            code[1:0]        = rpt_idx;
        end
        return code;
    endfunction

    // Position of the (single) set bit of a key vector
    function automatic logic [1:0] key_index(input logic [3:0] keys);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (keys[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/input_event_scheduler_fifo.sv
// First-word fall-through event FIFO. The head is a register loaded from
// the array (or bypassed from the write data when the FIFO is refilled
// from empty), so it holds steady until the next pop.
module event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [PW:0]      count_reg, count_next;
    logic [WIDTH-1:0] head_reg, head_next;
    logic             do_push, do_pop;

    assign do_pop      = pop && (count_reg != '0);
    assign do_push     = push && (count_reg < FULL);
    assign rd_ptr_next = rd_ptr_reg + PW'(do_pop);
    assign count_next  = count_reg + (PW+1)'(do_push) - (PW+1)'(do_pop);

    // Next head: bypass fresh data into an emptied FIFO, else read the array
    always_comb begin
        head_next = head_reg;
        if (do_push && (wr_ptr_reg == rd_ptr_next)) head_next = din;
        else if (count_next != '0)                  head_next = mem[rd_ptr_next];
    end

    // Storage array, no reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= din;
    end

    // Pointers, occupancy and head register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            head_reg   <= head_next;
        end
    end

    assign head  = head_reg;
    assign valid = (count_reg != '0);
    assign count = count_reg;

endmodule

// File: rtl/input_event_scheduler.sv
// Collects command/key pulses plus a key auto-repeat source, arbitrates
// them round-robin into an event FIFO and presents one event at a time.
module input_event_scheduler
    import input_event_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000,
    parameter int CNT_W        = 25
) (
    input  logic                          CLOCK_50,
    input  logic                          RESET_N,
    input  logic [3:0]                    CMD_En,
    input  logic [3:0]                    KEY_En,
    input  logic [3:0]                    KEY_Reg,
    input  logic                          REPEAT_EN,
    output logic                          EVT_Valid,
    output logic [3:0]                    EVT_Code,
    input  logic                          EVT_Ready,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_Count,
    output logic                          Overflow,
    input  logic                          Overflow_Clr
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    logic [NUM_SRC-1:0] pend_reg, pend_next, req_vec, gnt_vec;
    logic [7:0]         coalesce;
    logic [3:0]         rr_ptr_reg, gnt_idx, gnt_code;
    logic               gnt_found, grant, ovf_set, ovf_reg;

    rpt_state_t         state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [1:0]         rpt_idx_reg, rpt_code_idx_reg;
    logic               rpt_req_reg, key_onehot, key_multi, rpt_abort;

    assign req_vec = {rpt_req_reg, KEY_En, CMD_En};
    assign grant   = gnt_found && (FIFO_Count < FIFO_FULL);

    // Round-robin search: first pending source at or after the pointer
    always_comb begin
        logic [3:0] cand;
        cand      = '0;
        gnt_found = 1'b0;
        gnt_idx   = rr_ptr_reg;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = ring_add(rr_ptr_reg, 4'(k));
            if (!gnt_found && pend_reg[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Per-source pending bit: a pulse always wins over its own grant
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pend
            assign gnt_vec[gi]   = grant && (gnt_idx == 4'(gi));
            assign pend_next[gi] = req_vec[gi] | (pend_reg[gi] & ~gnt_vec[gi]);
        end
        for (genvar gi = 0; gi < 8; gi++) begin : g_coal
            assign coalesce[gi] = req_vec[gi] & pend_reg[gi] & ~gnt_vec[gi];
        end
    endgenerate

    assign ovf_set  = |coalesce;
    assign gnt_code = src_code(gnt_idx, rpt_code_idx_reg);

    // Pending bits, ring pointer, repeat code index and sticky overflow
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            pend_reg         <= '0;
            rr_ptr_reg       <= '0;
            rpt_code_idx_reg <= '0;
            ovf_reg          <= 1'b0;
        end else begin
            pend_reg <= pend_next;
            if (grant) rr_ptr_reg <= ring_add(gnt_idx, 4'd1);
            // A dropped repeat request must not retag the one still pending
            if (rpt_req_reg && (!pend_reg[SRC_RPT] || gnt_vec[SRC_RPT]))
                rpt_code_idx_reg <= rpt_idx_reg;
            if (ovf_set)           ovf_reg <= 1'b1;
            else if (Overflow_Clr) ovf_reg <= 1'b0;
        end
    end

    assign key_onehot = $onehot(KEY_Reg);
    assign key_multi  = !$onehot0(KEY_Reg);
    assign rpt_abort  = !REPEAT_EN || key_multi || !KEY_Reg[rpt_idx_reg];

    // Auto-repeat FSM; rpt_req_reg is a one-cycle registered request pulse
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            rpt_idx_reg <= '0;
            rpt_req_reg <= 1'b0;
        end else begin
            rpt_req_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (REPEAT_EN && key_onehot) begin
                        rpt_idx_reg <= key_index(KEY_Reg);
                        cnt_reg     <= '0;
                        state_reg   <= DELAY;
                    end
                end
                DELAY: begin
                    if (rpt_abort) begin
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end else if (cnt_reg == CNT_W'(REPEAT_DELAY - 1)) begin
                        rpt_req_reg <= 1'b1;
                        cnt_reg     <= '0;
                        state_reg   <= REPEAT;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                REPEAT: begin
                    if (rpt_abort) begin
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end else if (cnt_reg == CNT_W'(REPEAT_RATE - 1)) begin
                        rpt_req_reg <= 1'b1;
                        cnt_reg     <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    cnt_reg   <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (4)
    ) u_fifo (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .push  (grant),
        .pop   (EVT_Ready),
        .din   (gnt_code),
        .head  (EVT_Code),
        .valid (EVT_Valid),
        .count (FIFO_Count)
    );

    assign Overflow = ovf_reg;

endmodule

// File: tb/tb_input_event_scheduler.sv
// Bench for input_event_scheduler: directed scenarios followed by random
// traffic, all compared every cycle against a queue-based reference model.
module tb_input_event_scheduler;
    localparam int DEPTH = 4;
    localparam int D     = 8;
    localparam int R     = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] cmd_en, key_en, key_lvl, evt_code;
    logic       rpt_en, evt_valid, evt_ready, ovf, ovf_clr;
    logic [2:0] fifo_count;

    int tests = 0;
    int fails = 0;
    int rpt_seen = 0;

    // Reference model state
    bit       m_pend[9];
    int       m_rr;
    bit [3:0] q[$];
    bit       m_ovf;
    int       m_run, m_key;
    bit       m_fire;
    bit [1:0] m_fire_idx, m_rpt_idx;

    always #5 clk = ~clk;

    input_event_scheduler #(
        .FIFO_DEPTH(DEPTH), .REPEAT_DELAY(D), .REPEAT_RATE(R), .CNT_W(25)
    ) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .CMD_En(cmd_en), .KEY_En(key_en),
        .KEY_Reg(key_lvl), .REPEAT_EN(rpt_en), .EVT_Valid(evt_valid),
        .EVT_Code(evt_code), .EVT_Ready(evt_ready), .FIFO_Count(fifo_count),
        .Overflow(ovf), .Overflow_Clr(ovf_clr)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 9; i++) m_pend[i] = 1'b0;
        m_rr = 0; q.delete(); m_ovf = 1'b0;
        m_run = 0; m_key = 0; m_fire = 1'b0; m_fire_idx = '0; m_rpt_idx = '0;
    endtask

    // One clock of the specified behaviour, using the inputs seen at the edge
    task automatic model_step();
        bit       req[9];
        int       gw;
        bit [3:0] code;
        bit       oset, fire;
        int       kidx;
        for (int i = 0; i < 4; i++) begin
            req[i]     = cmd_en[i];
            req[4 + i] = key_en[i];
        end
        req[8] = m_fire;
        gw = -1;
        code = '0;
        if (q.size() < DEPTH) begin
            for (int k = 0; k < 9; k++) begin
                if (gw < 0 && m_pend[(m_rr + k) % 9]) gw = (m_rr + k) % 9;
            end
        end
        if (gw >= 0 && gw < 4)      code = {2'b10, 2'(gw)};
        else if (gw >= 4 && gw < 8) code = {2'b00, 2'(gw - 4)};
        else if (gw == 8)           code = {2'b01, m_rpt_idx};
        if (q.size() > 0 && evt_ready) begin
            $display("[TB] %0t event accepted code=%b", $time, q[0]);
            void'(q.pop_front());
        end
        if (gw >= 0) begin
            q.push_back(code);
            m_rr = (gw + 1) % 9;
        end
        if (req[8] && (!m_pend[8] || gw == 8)) m_rpt_idx = m_fire_idx;
        oset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8 && req[i] && m_pend[i] && i != gw) oset = 1'b1;
            m_pend[i] = req[i] || (m_pend[i] && i != gw);
        end
        if (oset)         m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        // Repeat: count consecutive cycles the same single key is held
        kidx = 0;
        for (int i = 0; i < 4; i++) if (key_lvl[i]) kidx = i;
        if (m_run > 0) begin
            if (rpt_en && $countones(key_lvl) == 1 && kidx == m_key) m_run++;
            else m_run = 0;
        end else if (rpt_en && $countones(key_lvl) == 1) begin
            m_run = 1;
            m_key = kidx;
        end
        fire = (m_run >= D + 1) && ((m_run - D - 1) % R == 0);
        m_fire = fire;
        m_fire_idx = 2'(m_key);
    endtask

    task automatic check_all();
        chk("valid", 8'(evt_valid), 8'(q.size() != 0));
        chk("count", 8'(fifo_count), 8'(q.size()));
        chk("overflow", 8'(ovf), 8'(m_ovf));
        if (q.size() != 0) chk("code", 8'(evt_code), 8'(q[0]));
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            if (evt_valid && evt_ready && evt_code == 4'b0110) rpt_seen++;
            @(posedge clk);
            model_step();
            #1;
            check_all();
            cmd_en = '0; key_en = '0; ovf_clr = 1'b0;
        end
    endtask

    task automatic pulse(input logic [3:0] c, input logic [3:0] k);
        cmd_en = c; key_en = k;
        step();
    endtask

    initial begin
        rst_n = 1'b0; cmd_en = '0; key_en = '0; key_lvl = '0;
        rpt_en = 1'b0; evt_ready = 1'b1; ovf_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 8'(evt_valid), 8'h00);
        chk("rst_code", 8'(evt_code), 8'h00);
        chk("rst_count", 8'(fifo_count), 8'h00);
        chk("rst_overflow", 8'(ovf), 8'h00);
        rst_n = 1'b1;

        // Simultaneous pulses with the pointer at source 0
        pulse(4'b0001, 4'b1000);
        step(4);

        // Single key pulse
        pulse(4'b0000, 4'b0100);
        step(4);

        // Six pulses with the consumer stalled, then drain
        evt_ready = 1'b0;
        pulse(4'b1111, 4'b0011);
        step(8);
        chk("full_count", 8'(fifo_count), 8'd4);
        evt_ready = 1'b1;
        step(10);

        // Coalesce a command while the FIFO is full
        evt_ready = 1'b0;
        pulse(4'b0000, 4'b1111);
        step(5);
        pulse(4'b0010, 4'b0000);
        pulse(4'b0010, 4'b0000);
        step(2);
        chk("ovf_set", 8'(ovf), 8'd1);
        evt_ready = 1'b1;
        step(8);
        chk("ovf_sticky", 8'(ovf), 8'd1);
        ovf_clr = 1'b1;
        step();
        chk("ovf_cleared", 8'(ovf), 8'd0);

        // Auto-repeat on KEY2, aborted by a second key
        rpt_seen = 0;
        rpt_en = 1'b1;
        key_lvl = 4'b0100;
        step(20);
        key_lvl = 4'b0110;
        step(6);
        key_lvl = 4'b0000;
        rpt_en = 1'b0;
        step(6);
        chk("rpt_count", 8'(rpt_seen), 8'd3);

        // Reset with three events queued
        evt_ready = 1'b0;
        pulse(4'b0111, 4'b0000);
        step(4);
        chk("pre_rst_count", 8'(fifo_count), 8'd3);
        rst_n = 1'b0;
        #1;
        chk("async_valid", 8'(evt_valid), 8'd0);
        chk("async_count", 8'(fifo_count), 8'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        evt_ready = 1'b1;
        step(5);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            cmd_en    = 4'($urandom) & 4'($urandom) & 4'($urandom);
            key_en    = 4'($urandom) & 4'($urandom) & 4'($urandom);
            evt_ready = ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 39) == 0) rpt_en = ~rpt_en;
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 5))
                    0: key_lvl = 4'b0000;
                    1: key_lvl = 4'b0001;
                    2: key_lvl = 4'b0010;
                    3: key_lvl = 4'b0100;
                    4: key_lvl = 4'b1000;
                    default: key_lvl = 4'b0011;
                endcase
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
